lcd_cmd_sched: RTL and testbench
================================

# lcd_cmd_sched

Command scheduler in front of `LCD_CTRL`. It merges two command sources into the single `cmd`/`cmd_valid` port and honours the controller's `busy` handshake:
- a host push interface, buffered in a small FIFO;
- a script stored in a synchronous command ROM (IROM-style, active-low enable, 1-cycle read latency).

It replaces the bench-side command feeder in the image display path. It sits between host/ROM and `LCD_CTRL`.

## Interface
- `HDEPTH`, default 4: host FIFO depth; power of two, ≥2.
- `SCRIPT_LEN`, default 45: number of script commands, 1..64.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `host_cmd` in 3: host command code, 0..7.
- `host_valid` in 1: host offers `host_cmd`.
- `host_ready` out 1: FIFO not full; a push occurs on any edge where `host_valid & host_ready`.
- `start` in 1: one-cycle pulse that launches the script.
- `script_en` out 1: command ROM chip enable, active-low, registered.
- `script_a` out 6: command ROM address, registered.
- `script_q` in 3: ROM data, valid the cycle after the ROM samples enable and address.
- `cmd` out 3: command to `LCD_CTRL`, registered.
- `cmd_valid` out 1: one-cycle command strobe, registered.
- `busy` in 1: `LCD_CTRL` is processing.
- `sched_idle` out 1: in ARB, FIFO empty, no script pending.
- `script_done` out 1: one-cycle pulse after the last script command completes.

## Operation
- States: ARB, FETCH, LOAD, GUARD, WAIT.
- **ARB.** Pending sources are host (FIFO non-empty) and script (`script_active` and `ptr < SCRIPT_LEN`). If `busy` is 0 and one or more sources are pending:
  - Arbitration is round-robin on a `last_grant` bit; with a single pending source, that source wins.
  - Host grant: pop the FIFO; `cmd <=` head; `cmd_valid <= 1`; next state GUARD.
  - Script grant: `script_en <= 0`; `script_a <= ptr`; next state FETCH.
- **FETCH.** `script_en <= 1`; next state LOAD. The ROM samples on this edge.
- **LOAD.** `cmd <= script_q`; `cmd_valid <= 1`; `ptr <= ptr + 1`; next state GUARD.
- **GUARD.** `cmd_valid <= 0`. `busy` is ignored, because `LCD_CTRL` raises it on the edge after the strobe. Next state WAIT.
- **WAIT.** Remain until `busy` is 0, then go to ARB.
  - If the command just completed was script command `SCRIPT_LEN-1`: pulse `script_done`, clear `script_active`.
- **`start`.**
  - When the script is not active: `ptr <= 0`, `script_active <= 1`.
  - When the script is active: ignored.
- **FIFO.**
  - Read and write pointers wrap modulo `HDEPTH`; occupancy count is `clog2(HDEPTH)+1` bits.
  - `host_ready = (count != HDEPTH)`, combinational from the registered count. A pop in the same cycle does not raise `host_ready` while the FIFO is full.
  - A simultaneous push and pop leaves the count unchanged.
- **Ordering.** Host commands are issued in push order. Script commands are issued in address order 0..`SCRIPT_LEN-1`.

## Timing
- **Reset values:**
  - State ARB.
  - `cmd` = 0, `cmd_valid` = 0, `script_en` = 1, `script_a` = 0, `script_done` = 0.
  - `host_ready` = 1, `sched_idle` = 1.
  - FIFO empty, `script_active` = 0, `last_grant` = script (so host wins the first tie).
- **Host latency:** push at edge N, with the FSM in ARB and `busy` = 0, gives `cmd_valid` high from edge N+1 to N+2.
- **Script latency:** grant at edge E gives `script_en` low from E to E+1, and `cmd_valid` high from E+2 to E+3.
- `cmd_valid` is never high for two consecutive cycles. At most one command is outstanding.
- **Reset mid-operation:** FIFO flushed, script aborted, no `script_done`. A `cmd_valid` in flight drops at the reset edge.
- **`reset` and `start` on the same edge:** reset wins.
- **`SCRIPT_LEN` = 1:** `script_done` pulses after the single command's WAIT exit.

## Structure
- Shared package `lcd_pkg` holds:
  - command codes: WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, AVERAGE=5, MIRROR_X=6, MIRROR_Y=7;
  - the scheduler state enum;
  - `CMD_W`=3 and `ROM_AW`=6.
- One sub-module, `lcd_cmd_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count.
- The FSM and arbiter stay in the top level.

## Test plan
- **Host only, `busy` held 0:** push 3, 1, 6 on consecutive edges. `cmd_valid` pulses carry 3, 1, 6, each issue 3 cycles apart. `sched_idle` returns to 1 afterwards.
- **FIFO full:** hold `busy` = 1 and push 5 commands with `HDEPTH`=4. `host_ready` goes 0 after the 4th push and the 5th is not accepted. Release `busy`: exactly 4 commands are issued, in order.
- **Script run:** `SCRIPT_LEN`=45, ROM model loaded with cmd1 data, `busy` model high for 2 cycles per command. 45 strobes match ROM order, `script_a` runs 0..44, and one `script_done` pulse follows the final command.
- **Round-robin:** script active and host FIFO holding 2, 2. Issue order is host(2), script[0], host(2), script[1], script[2].
- **`busy` guard:** `busy` rises one cycle after `cmd_valid`. No second strobe occurs before `busy` falls, and no strobe occurs in the GUARD cycle.
- **Reset mid-script:** assert `reset` while in LOAD at `ptr`=10. All outputs reach their reset values, with no `script_done`. A new `start` restarts at `script_a` = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes, widths and the
// scheduler state encoding.
package lcd_pkg;

    localparam int CMD_W  = 3;
    localparam int ROM_AW = 6;

    localparam logic [CMD_W-1:0] CMD_WRITE       = 3'd0;
    localparam logic [CMD_W-1:0] CMD_SHIFT_UP    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_SHIFT_RIGHT = 3'd4;
    localparam logic [CMD_W-1:0] CMD_AVERAGE     = 3'd5;
    localparam logic [CMD_W-1:0] CMD_MIRROR_X    = 3'd6;
    localparam logic [CMD_W-1:0] CMD_MIRROR_Y    = 3'd7;

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO buffering host commands ahead of the scheduler.
// Push into a full FIFO and pop from an empty one are ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == CNT_MAX);
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= {AW{1'b0}};
            wr_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_q <= rd_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Merges buffered host commands and a ROM-resident script into the single
// LCD_CTRL command port, one outstanding command at a time.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int HDEPTH     = 4,
    parameter int SCRIPT_LEN = 45
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  host_cmd,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              start,
    output logic              script_en,
    output logic [ROM_AW-1:0] script_a,
    input  logic [CMD_W-1:0]  script_q,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    output logic              sched_idle,
    output logic              script_done
);
    localparam int PW = ROM_AW + 1;
    localparam logic [PW-1:0] LEN_C   = PW'(SCRIPT_LEN);
    localparam logic [PW-1:0] LAST_C  = PW'(SCRIPT_LEN - 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic GRANT_HOST   = 1'b0;
    localparam logic GRANT_SCRIPT = 1'b1;

    sched_state_t      state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              script_en_q, script_en_d;
    logic [ROM_AW-1:0] script_a_q, script_a_d;
    logic              script_done_q, script_done_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              active_q, active_d;
    logic              last_grant_q, last_grant_d;
    logic              is_last_q, is_last_d;

    logic              fifo_pop_s;
    logic              fifo_push_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CMD_W-1:0]  fifo_head_s;
    logic [$clog2(HDEPTH):0] fifo_count_s;
    logic              host_pend_s;
    logic              scr_pend_s;
    logic              grant_host_s;

    assign host_ready   = ~fifo_full_s;
    assign fifo_push_s  = host_valid & ~fifo_full_s;
    assign host_pend_s  = (fifo_count_s != '0);
    assign scr_pend_s   = active_q & (ptr_q < LEN_C);
    // Round-robin: host wins ties only when the script was served last.
    assign grant_host_s = host_pend_s & (~scr_pend_s | (last_grant_q == GRANT_SCRIPT));

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign script_en   = script_en_q;
    assign script_a    = script_a_q;
    assign script_done = script_done_q;
    assign sched_idle  = (state_q == ST_ARB) & fifo_empty_s & ~scr_pend_s;

    lcd_cmd_fifo #(.DEPTH(HDEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push_s),
        .din_i   (host_cmd),
        .pop_i   (fifo_pop_s),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cmd_valid_d   = 1'b0;
        script_en_d   = script_en_q;
        script_a_d    = script_a_q;
        script_done_d = 1'b0;
        ptr_d         = ptr_q;
        active_d      = active_q;
        last_grant_d  = last_grant_q;
        is_last_d     = is_last_q;
        fifo_pop_s    = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (!busy && (host_pend_s || scr_pend_s)) begin
                    if (grant_host_s) begin
                        fifo_pop_s   = 1'b1;
                        cmd_d        = fifo_head_s;
                        cmd_valid_d  = 1'b1;
                        last_grant_d = GRANT_HOST;
                        is_last_d    = 1'b0;
                        state_d      = ST_GUARD;
                    end else begin
                        script_en_d  = 1'b0;
                        script_a_d   = ptr_q[ROM_AW-1:0];
                        last_grant_d = GRANT_SCRIPT;
                        state_d      = ST_FETCH;
                    end
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_FETCH: begin
                script_en_d = 1'b1;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                cmd_d       = script_q;
                cmd_valid_d = 1'b1;
                ptr_d       = ptr_q + PTR_ONE;
                is_last_d   = (ptr_q == LAST_C);
                state_d     = ST_GUARD;
            end
            // LCD_CTRL only raises busy on the edge after the strobe.
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!busy) begin
                    state_d = ST_ARB;
                    if (is_last_q) begin
                        script_done_d = 1'b1;
                        active_d      = 1'b0;
                        is_last_d     = 1'b0;
                    end else begin
                        script_done_d = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
        if (start && !active_q) begin
            ptr_d    = {PW{1'b0}};
            active_d = 1'b1;
        end else begin
            active_d = active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ARB;
            cmd_q         <= {CMD_W{1'b0}};
            cmd_valid_q   <= 1'b0;
            script_en_q   <= 1'b1;
            script_a_q    <= {ROM_AW{1'b0}};
            script_done_q <= 1'b0;
            ptr_q         <= {PW{1'b0}};
            active_q      <= 1'b0;
            last_grant_q  <= GRANT_SCRIPT;
            is_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cmd_valid_q   <= cmd_valid_d;
            script_en_q   <= script_en_d;
            script_a_q    <= script_a_d;
            script_done_q <= script_done_d;
            ptr_q         <= ptr_d;
            active_q      <= active_d;
            last_grant_q  <= last_grant_d;
            is_last_q     <= is_last_d;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched with a command ROM and a simple LCD_CTRL
// busy model that holds busy for two cycles after each strobe.
module tb_lcd_cmd_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] host_cmd = 3'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       start = 1'b0;
    logic       script_en;
    logic [5:0] script_a;
    logic [2:0] script_q;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       sched_idle;
    logic       script_done;

    logic [2:0] rom [64];
    logic [2:0] rom_q = 3'd0;
    logic       busy_force = 1'b0;
    logic       model_en = 1'b0;
    int         bcnt = 0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       prev_cv = 1'b0;
    logic [2:0] sq_cmd [$];
    int         sq_cyc [$];
    logic [5:0] aq [$];

    lcd_cmd_sched #(.HDEPTH(4), .SCRIPT_LEN(45)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .start(start), .script_en(script_en),
        .script_a(script_a), .script_q(script_q), .cmd(cmd), .cmd_valid(cmd_valid),
        .busy(busy), .sched_idle(sched_idle), .script_done(script_done)
    );

    always #5 clk = ~clk;

    // Command ROM: one-cycle read latency, active-low enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (script_en === 1'b0) rom_q <= rom[script_a];
        if (cmd_valid === 1'b1) bcnt <= 2;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign script_q = rom_q;
    assign busy = busy_force | (model_en & (bcnt != 0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: records issued commands and checks the one-outstanding rule.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            chk("cv_back_to_back", {31'd0, prev_cv}, 32'd0);
            chk("strobe_while_busy", {31'd0, busy}, 32'd0);
            sq_cmd.push_back(cmd);
            sq_cyc.push_back(cyc);
        end
        if (script_en === 1'b0) aq.push_back(script_a);
        if (script_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        prev_cv <= cmd_valid;
    end

    task automatic clear_q();
        sq_cmd.delete();
        sq_cyc.delete();
        aq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"}, {29'd0, cmd}, 32'd0);
        chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_script_en"}, {31'd0, script_en}, 32'd1);
        chk({tag, "_script_a"}, {26'd0, script_a}, 32'd0);
        chk({tag, "_script_done"}, {31'd0, script_done}, 32'd0);
        chk({tag, "_host_ready"}, {31'd0, host_ready}, 32'd1);
        chk({tag, "_sched_idle"}, {31'd0, sched_idle}, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t0;
        int d0;
        int k;
        logic [2:0] fv [5];
        for (int i = 0; i < 64; i++) rom[i] = 3'((i * 3 + 5) % 8);

        // Reset, with start asserted on the final reset edge: reset must win.
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("reset_start_no_script_en", {31'd0, script_en}, 32'd1);
        chk("reset_start_idle", {31'd0, sched_idle}, 32'd1);

        // Host only, busy held low: 3, 1, 6 issued three cycles apart.
        clear_q();
        t0 = cyc;
        host_valid = 1'b1; host_cmd = 3'd3;
        @(negedge clk); host_cmd = 3'd1;
        @(negedge clk); host_cmd = 3'd6;
        @(negedge clk); host_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("host_count", sq_cmd.size(), 32'd3);
        if (sq_cmd.size() == 3) begin
            chk("host_cmd0", {29'd0, sq_cmd[0]}, 32'd3);
            chk("host_cmd1", {29'd0, sq_cmd[1]}, 32'd1);
            chk("host_cmd2", {29'd0, sq_cmd[2]}, 32'd6);
            chk("host_latency", sq_cyc[0] - t0, 32'd2);
            chk("host_gap01", sq_cyc[1] - sq_cyc[0], 32'd3);
            chk("host_gap12", sq_cyc[2] - sq_cyc[1], 32'd3);
        end
        chk("host_idle_after", {31'd0, sched_idle}, 32'd1);

        // FIFO full: five pushes while busy, only four accepted.
        clear_q();
        fv[0] = 3'd4; fv[1] = 3'd5; fv[2] = 3'd6; fv[3] = 3'd7; fv[4] = 3'd0;
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_cmd = fv[i];
            host_valid = 1'b1;
            @(negedge clk);
            chk("full_host_ready", {31'd0, host_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        host_valid = 1'b0;
        chk("full_no_issue_while_busy", sq_cmd.size(), 32'd0);
        busy_force = 1'b0;
        model_en = 1'b1;
        repeat (60) @(negedge clk);
        chk("full_issue_count", sq_cmd.size(), 32'd4);
        for (int i = 0; i < 4 && i < sq_cmd.size(); i++)
            chk("full_order", {29'd0, sq_cmd[i]}, {29'd0, fv[i]});
        chk("full_ready_after", {31'd0, host_ready}, 32'd1);

        // Full script run with the busy model.
        clear_q();
        d0 = done_cnt;
        pulse_start();
        k = 0;
        while (done_cnt == d0 && k < 2000) begin @(negedge clk); k++; end
        chk("script_done_seen", done_cnt - d0, 32'd1);
        repeat (4) @(negedge clk);
        chk("script_done_single", done_cnt - d0, 32'd1);
        chk("script_strobes", sq_cmd.size(), 32'd45);
        chk("script_a_count", aq.size(), 32'd45);
        for (int i = 0; i < 45 && i < sq_cmd.size(); i++)
            chk("script_cmd", {29'd0, sq_cmd[i]}, {29'd0, rom[i]});
        for (int i = 0; i < 45 && i < aq.size(); i++)
            chk("script_addr", {26'd0, aq[i]}, i);
        if (sq_cyc.size() == 45)
            chk("script_done_timing", done_cyc - sq_cyc[44], 32'd4);
        chk("script_idle_after", {31'd0, sched_idle}, 32'd1);

        // Round-robin: host 2,2 queued with the script pending.
        clear_q();
        busy_force = 1'b1;
        @(negedge clk); host_cmd = 3'd2; host_valid = 1'b1;
        @(negedge clk); @(negedge clk); host_valid = 1'b0;
        pulse_start();
        busy_force = 1'b0;
        k = 0;
        while (sq_cmd.size() < 5 && k < 200) begin @(negedge clk); k++; end
        chk("rr_count", (sq_cmd.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        if (sq_cmd.size() >= 5) begin
            chk("rr_0_host", {29'd0, sq_cmd[0]}, 32'd2);
            chk("rr_1_scr0", {29'd0, sq_cmd[1]}, {29'd0, rom[0]});
            chk("rr_2_host", {29'd0, sq_cmd[2]}, 32'd2);
            chk("rr_3_scr1", {29'd0, sq_cmd[3]}, {29'd0, rom[1]});
            chk("rr_4_scr2", {29'd0, sq_cmd[4]}, {29'd0, rom[2]});
        end
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 2000) begin @(negedge clk); k++; end
        chk("rr_script_done", done_cnt - d0, 32'd1);
        repeat (3) @(negedge clk);

        // Reset while in LOAD for script command 10.
        clear_q();
        pulse_start();
        k = 0;
        while (!(script_en === 1'b0 && script_a == 6'd10) && k < 500) begin
            @(negedge clk); k++;
        end
        chk("mid_fetch10_found", {26'd0, script_a}, 32'd10);
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check_reset_vals("mid_reset");
        chk("mid_reset_strobes", sq_cmd.size(), 32'd10);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_reset_no_done", done_cnt - d0, 32'd0);
        chk("mid_reset_idle", {31'd0, sched_idle}, 32'd1);
        aq.delete();
        pulse_start();
        k = 0;
        while (aq.size() == 0 && k < 50) begin @(negedge clk); k++; end
        chk("restart_fetch_seen", (aq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (aq.size() > 0) chk("restart_addr0", {26'd0, aq[0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
